// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if
// Purpose: bundles the command port, the write and read data streams, the
// completion pulse and the memory-side port of mem_burst_ctrl.
// Signals:
//   cmd_valid / cmd_ready / cmd_write / cmd_addr / cmd_len : burst command
//   wr_valid / wr_ready / wr_data                          : write data stream
//   rd_valid / rd_ready / rd_data                          : read data stream
//   done                                                   : burst completion pulse
//   mem_write / mem_read / mem_addr / mem_data_in          : requests to the memory
//   mem_data_out                                           : registered read data from the memory
// Modports: slave = the burst controller, master = its environment
// (command source, stream endpoints and the memory itself).
interface mem_burst_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic              done;

  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  mem_data_out,
    output cmd_ready, wr_ready, rd_valid, rd_data, done,
    output mem_write, mem_read, mem_addr, mem_data_in
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output mem_data_out,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done,
    input  mem_write, mem_read, mem_addr, mem_data_in
  );

endinterface

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
// Purpose: upstream master for a 32x8 single-port memory with one-cycle
// registered read data. Accepts write/read burst commands, streams write
// beats into consecutive (wrapping) addresses and returns read beats through
// a small skid FIFO so the read stream can be backpressured without losing data.
// Ports:
//   clk  : clock, shared with the memory
//   rst  : synchronous active-high reset
//   bus  : mem_burst_ctrl_if.slave -- command, write stream, read stream,
//          done pulse and the registered memory request port
module mem_burst_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int SKID_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_burst_ctrl_if.slave     bus
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int OUT_W = PTR_W + 2;

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    PtrOne  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]  DepthV  = SKID_DEPTH[OUT_W-1:0];

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] curAddr_q, curAddr_d;
  logic [ADDR_W:0]   issueLeft_q, issueLeft_d;
  logic [ADDR_W:0]   popLeft_q, popLeft_d;
  logic              memWrite_q, memWrite_d;
  logic              memRead_q, memRead_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memDataIn_q, memDataIn_d;
  logic              done_q, done_d;
  logic              rdPending_q;

  logic [DATA_W-1:0] fifoMem_q [SKID_DEPTH];
  logic [PTR_W:0]    wrPtr_q, rdPtr_q;
  logic [PTR_W:0]    fifoOcc;
  logic [OUT_W-1:0]  outstanding;
  logic              rdValid, pop, issue, cmdReady, wrReady;

  // Pointers carry one extra bit so full and empty are distinguishable.
  // Every read that has been issued but not yet popped already owns a FIFO
  // slot: a new read may go out only if that total, less this cycle's pop,
  // leaves room, so returning data can never find the FIFO full.
  assign fifoOcc     = wrPtr_q - rdPtr_q;
  assign rdValid     = (fifoOcc != '0);
  assign pop         = rdValid & bus.rd_ready;
  assign outstanding = {1'b0, fifoOcc}
                     + {{(OUT_W-1){1'b0}}, memRead_q}
                     + {{(OUT_W-1){1'b0}}, rdPending_q}
                     - {{(OUT_W-1){1'b0}}, pop};
  assign issue       = (state_q == READ) && (issueLeft_q != '0) && (outstanding < DepthV);

  // Next-state and request logic. The write path counts beats down in
  // issueLeft; the read path uses issueLeft for reads still to send and
  // popLeft for beats still to hand to the consumer.
  always_comb begin
    state_d     = state_q;
    curAddr_d   = curAddr_q;
    issueLeft_d = issueLeft_q;
    popLeft_d   = pop ? (popLeft_q - CntOne) : popLeft_q;
    memWrite_d  = 1'b0;
    memRead_d   = 1'b0;
    memAddr_d   = memAddr_q;
    memDataIn_d = memDataIn_q;
    done_d      = 1'b0;
    cmdReady    = 1'b0;
    wrReady     = 1'b0;
    case (state_q)
      IDLE: begin
        cmdReady = 1'b1;
        if (bus.cmd_valid) begin
          curAddr_d   = bus.cmd_addr;
          issueLeft_d = {1'b0, bus.cmd_len} + CntOne;
          popLeft_d   = {1'b0, bus.cmd_len} + CntOne;
          state_d     = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wrReady = 1'b1;
        if (bus.wr_valid) begin
          memWrite_d  = 1'b1;
          memAddr_d   = curAddr_q;
          memDataIn_d = bus.wr_data;
          curAddr_d   = curAddr_q + AddrOne;
          issueLeft_d = issueLeft_q - CntOne;
          if (issueLeft_q == CntOne) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          memRead_d   = 1'b1;
          memAddr_d   = curAddr_q;
          curAddr_d   = curAddr_q + AddrOne;
          issueLeft_d = issueLeft_q - CntOne;
          if (issueLeft_q == CntOne) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (popLeft_q == CntOne)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the registered memory request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      curAddr_q   <= '0;
      issueLeft_q <= '0;
      popLeft_q   <= '0;
      memWrite_q  <= 1'b0;
      memRead_q   <= 1'b0;
      memAddr_q   <= '0;
      memDataIn_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      curAddr_q   <= curAddr_d;
      issueLeft_q <= issueLeft_d;
      popLeft_q   <= popLeft_d;
      memWrite_q  <= memWrite_d;
      memRead_q   <= memRead_d;
      memAddr_q   <= memAddr_d;
      memDataIn_q <= memDataIn_d;
      done_q      <= done_d;
    end
  end

  // Read return path. memRead_q marks a read the memory is servicing this
  // cycle; rdPending_q marks that its data is on mem_data_out now and gets
  // captured at the end of the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPending_q <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        fifoMem_q[i] <= '0;
      end
    end else begin
      rdPending_q <= memRead_q;
      if (rdPending_q) begin
        fifoMem_q[wrPtr_q[PTR_W-1:0]] <= bus.mem_data_out;
        wrPtr_q <= wrPtr_q + PtrOne;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PtrOne;
      end
    end
  end

  assign bus.cmd_ready   = cmdReady;
  assign bus.wr_ready    = wrReady;
  assign bus.rd_valid    = rdValid;
  assign bus.rd_data     = fifoMem_q[rdPtr_q[PTR_W-1:0]];
  assign bus.done        = done_q;
  assign bus.mem_write   = memWrite_q;
  assign bus.mem_read    = memRead_q;
  assign bus.mem_addr    = memAddr_q;
  assign bus.mem_data_in = memDataIn_q;

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Upstream master for the 32x8 single-port memory. The memory has registered read data, one-cycle read latency, and no reset.
- Accepts burst commands on a valid/ready port: operation, start address and length.
- Write bursts: streams data from a write stream into consecutive memory locations.
- Read bursts: streams memory contents out through a backpressured read stream, buffered by an internal skid FIFO.

Parameters:
- ADDR_W, 5, memory address width (32 locations).
- DATA_W, 8, data width.
- SKID_DEPTH, 4, read-return buffer entries (power of two, >=4).

Ports:
- clk  in  1  clock, shared with the memory.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle and able to accept a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  burst start address.
- cmd_len  in  ADDR_W  beats minus one (0..31 gives 1..32 beats).
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat offered.
- rd_ready  in  1  consumer accepts read beat.
- rd_data  out  DATA_W  read beat data.
- done  out  1  one-cycle pulse marking burst completion.
- mem_write  out  1  to memory write.
- mem_read  out  1  to memory read.
- mem_addr  out  ADDR_W  to memory addr.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out.

Behaviour:

Reset and register rules:
- Reset is synchronous and active-high on rst; the only clock is clk.
- Reset values: state IDLE, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, done=0, mem_write=0, mem_read=0, mem_addr=0, mem_data_in=0.
- Reset also clears the skid FIFO and in-flight tracking.
- All mem_* outputs are registered. mem_write and mem_read are never high in the same cycle.

State machine (IDLE, WRITE, READ, DRAIN):
- IDLE: cmd_ready=1. A cmd handshake latches addr, beat count (cmd_len+1) and op, then goes to WRITE or READ.
- cmd_ready=0 in every state other than IDLE; cmd_valid is ignored there.

Write burst:
- In WRITE, wr_ready=1. Each wr handshake registers mem_write=1, mem_addr=cur_addr and mem_data_in=wr_data for the next cycle only. The memory commits at the end of that cycle.
- No handshake means mem_write=0 next cycle. Gaps in wr_valid are allowed.
- On the last handshake, return to IDLE. done=1 in the same cycle as the last mem_write.

Address and length:
- cur_addr increments by 1 modulo 2^ADDR_W per beat: 31 wraps to 0.
- A 32-beat burst touches every location exactly once.

Read burst, issue side:
- In READ, one read is issued per cycle: registered mem_read=1, mem_addr=cur_addr.
- A read may issue only while issued_remaining>0 and (fifo_occ + inflight - pop_this_cycle) < SKID_DEPTH.
- Read data appears on mem_data_out the cycle after mem_read is high. It is captured into the FIFO at the end of that cycle.
- A 2-stage valid shift register tracks in-flight reads.

Read burst, return side:
- rd_valid = FIFO non-empty; rd_data = FIFO head. A pop occurs on rd_valid & rd_ready.
- Latency: cmd handshake at edge E0, mem_read high after E1, capture at E3, rd_valid high after E3 (3 edges).
- With rd_ready held at 1, throughput is one beat per cycle.
- Once all reads are issued, go to DRAIN. Stay there until the final beat is popped.
- done pulses in the cycle after the final pop; the state is IDLE in that same cycle.

Boundary conditions:
- FIFO full: no issue that cycle. No read data may ever be lost or reordered.
- Simultaneous capture and pop on a full FIFO is legal.
- A new command accepted in the done cycle of a write starts no earlier than after the last write commits, so there is no read-after-write hazard.
- Reset mid-burst: all in-flight data and FIFO contents are dropped and outputs take their reset values next cycle. Memory contents are not touched by reset.

Test Plan:
- Write cmd addr=2, len=3, wr_data A0,A1,A2,A3 with wr_valid=1 -> mem_write high 4 consecutive cycles at addr 2,3,4,5 with matching data. done=1 coincident with the 4th mem_write. cmd_ready=1 the following cycle.
- Read cmd addr=2, len=3, rd_ready=1 -> rd_valid first high 3 edges after the cmd handshake. rd_data A0..A3 on consecutive cycles. done one cycle after the last beat.
- Wrap: write addr=30, len=3, data 11,22,33,44, then read addr=30, len=3 -> mem_addr sequence 30,31,0,1 on both bursts. Read returns 11,22,33,44.
- Backpressure: fill 0..31 with value=addr. Read addr=0, len=31 with rd_ready toggling 1-0-0-1 randomly -> 32 beats in order 0..31, FIFO occupancy never exceeds 4, mem_read never high with the FIFO full plus in-flight.
- Stall/ignore: write burst with wr_valid low every other cycle -> mem_write only after handshakes. cmd_valid asserted mid-burst -> cmd_ready stays 0 and the command is not accepted.
- Reset after 2 of 8 read beats -> next cycle rd_valid=0, mem_read=0, done=0, cmd_ready=1. A subsequent read of the same range returns the correct full data.
